// File: rtl/capture_pkg.sv
// capture_pkg: shared state type, CSR map and writedata layout for the capture write arbiter
package capture_pkg;
    typedef enum logic [1:0] {IDLE, RUN, FULL} state_t;
    localparam logic [3:0] CSR_CTRL   = 4'd0;
    localparam logic [3:0] CSR_STATUS = 4'd1;
    localparam logic [3:0] CSR_WR_PTR = 4'd2;
    localparam logic [3:0] CSR_DROP0  = 4'd3;
    localparam logic [3:0] CSR_DROP1  = 4'd4;
    localparam logic [3:0] CSR_COUNT0 = 4'd5;
    localparam logic [3:0] CSR_COUNT1 = 4'd6;
    localparam logic [3:0] CAPTURE_TAG = 4'hF;
    localparam int DATA_W   = 36;
    localparam int PORT_BIT = 36;
    localparam int TAG_LSB  = 60;
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return v + {31'd0, ~&v};
    endfunction
endpackage

// File: rtl/capture_fifo.sv
// capture_fifo: sync FIFO with first-word fall-through head; push onto a full FIFO is taken when a pop happens the same cycle
module capture_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 36
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0] wp, rp;
    logic do_push, do_pop;
    assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign empty = wp == rp;
    assign dout = mem[rp[AW-1:0]];
    assign do_push = push & (~full | pop);
    assign do_pop = pop & ~empty;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            wp <= '0;
            rp <= '0;
        end else if (clr) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + (AW+1)'(1);
            if (do_pop) rp <= rp + (AW+1)'(1);
        end
    always_ff @(posedge clk)
        if (do_push) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/capture_write_arbiter.sv
// capture_write_arbiter: two valid-only snoop streams share one Avalon-MM write master into capture RAM
module capture_write_arbiter
    import capture_pkg::*;
#(
    parameter int ADDR_W = 20,
    parameter int FIFO_DEPTH = 4,
    parameter logic [3:0] TAG = CAPTURE_TAG
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] port0_st_data,
    input  logic              port0_st_valid,
    input  logic [DATA_W-1:0] port1_st_data,
    input  logic              port1_st_valid,
    output logic [ADDR_W-1:0] mem_address,
    output logic [63:0]       mem_writedata,
    output logic              mem_write,
    input  logic              mem_waitrequest,
    input  logic [3:0]        csr_address,
    input  logic              csr_read,
    input  logic              csr_write,
    input  logic [31:0]       csr_writedata,
    output logic [31:0]       csr_readdata,
    output logic              snoop_reset
);
    state_t state;
    logic ctrl_en, ctrl_wrap, clr_pend, gnt, last;
    logic accept, clr_go, ctrl_wr, en_n, issue, sel, top_hit;
    logic [1:0] valid, full, empty, pop, drop_inc;
    logic [DATA_W-1:0] st_data [2];
    logic [DATA_W-1:0] head [2];
    logic [31:0] drop [2];
    logic [31:0] count [2];
    logic unused_wdata;
    assign valid = {port1_st_valid, port0_st_valid};
    assign st_data[0] = port0_st_data;
    assign st_data[1] = port1_st_data;
    assign accept = mem_write & ~mem_waitrequest;
    // A pending clear waits for the in-flight write to be accepted
    assign clr_go = clr_pend & (~mem_write | accept);
    assign ctrl_wr = csr_write & (csr_address == CSR_CTRL);
    assign en_n = ctrl_wr ? csr_writedata[0] : ctrl_en;
    assign issue = ~mem_write & (state == RUN) & ~clr_pend & ~&empty;
    assign sel = ~|empty ? ~last : empty[0];
    assign top_hit = accept & (state == RUN) & (&mem_address) & ~ctrl_wrap;
    assign unused_wdata = ^csr_writedata[31:3];
    for (genvar i = 0; i < 2; i++) begin : g_port
        assign pop[i] = accept & (gnt == 1'(i));
        assign drop_inc[i] = valid[i] & (((state == RUN) & full[i] & ~pop[i]) | (state == FULL));
        capture_fifo #(.DEPTH(FIFO_DEPTH), .W(DATA_W)) u_fifo (
            .clk    (clk),
            .reset_n(reset_n),
            .clr    (clr_go),
            .push   (valid[i] & (state == RUN)),
            .pop    (pop[i]),
            .din    (st_data[i]),
            .dout   (head[i]),
            .full   (full[i]),
            .empty  (empty[i])
        );
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state <= IDLE;
            ctrl_en <= 1'b0;
            ctrl_wrap <= 1'b0;
            clr_pend <= 1'b0;
            snoop_reset <= 1'b0;
            mem_write <= 1'b0;
            mem_address <= '0;
            mem_writedata <= '0;
            gnt <= 1'b0;
            last <= 1'b1;
            drop <= '{default: '0};
            count <= '{default: '0};
        end else begin
            ctrl_en <= en_n;
            ctrl_wrap <= ctrl_wr ? csr_writedata[1] : ctrl_wrap;
            clr_pend <= (ctrl_wr & csr_writedata[2]) | (clr_pend & ~clr_go);
            snoop_reset <= clr_go;
            state <= clr_go ? (en_n ? RUN : IDLE) : !en_n ? IDLE : (state == IDLE) ? RUN : top_hit ? FULL : state;
            mem_write <= issue | (mem_write & ~accept);
            if (issue) begin
                gnt <= sel;
                last <= sel;
                mem_writedata <= {TAG, {(TAG_LSB-PORT_BIT-1){1'b0}}, sel, head[sel]};
            end
            if (clr_go) begin
                mem_address <= '0;
                drop <= '{default: '0};
                count <= '{default: '0};
            end else begin
                if (accept) mem_address <= mem_address + ADDR_W'(1);
                for (int i = 0; i < 2; i++) begin
                    if (pop[i]) count[i] <= count[i] + 32'd1;
                    if (drop_inc[i]) drop[i] <= sat_inc(drop[i]);
                end
            end
        end
    always_comb begin
        csr_readdata = '0;
        if (csr_read)
            case (csr_address)
                CSR_CTRL:   csr_readdata = {30'd0, ctrl_wrap, ctrl_en};
                CSR_STATUS: csr_readdata = {29'd0, mem_write, state == FULL, state == RUN};
                CSR_WR_PTR: csr_readdata = 32'(mem_address);
                CSR_DROP0:  csr_readdata = drop[0];
                CSR_DROP1:  csr_readdata = drop[1];
                CSR_COUNT0: csr_readdata = count[0];
                CSR_COUNT1: csr_readdata = count[1];
                default:    csr_readdata = '0;
            endcase
    end
endmodule

// File: tb/tb_capture_write_arbiter.sv
// tb_capture_write_arbiter: random and directed stimulus checked against a queue-based model of the capture arbiter
module tb_capture_write_arbiter;
    localparam int AW = 4;
    localparam int DEPTH = 4;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [35:0] port0_st_data = '0, port1_st_data = '0;
    logic port0_st_valid = 1'b0, port1_st_valid = 1'b0;
    logic [AW-1:0] mem_address;
    logic [63:0] mem_writedata;
    logic mem_write, snoop_reset;
    logic mem_waitrequest = 1'b0;
    logic [3:0] csr_address = '0;
    logic csr_read = 1'b0, csr_write = 1'b0;
    logic [31:0] csr_writedata = '0;
    logic [31:0] csr_readdata;
    int checks = 0;
    int failures = 0;
    bit [35:0] q0[$], q1[$];
    int st = 0;
    bit en, wrap, pend, busy, port, snoop;
    bit last = 1'b1;
    bit [AW-1:0] addr;
    bit [63:0] wdat;
    bit [31:0] drop0, drop1, cnt0, cnt1;
    always #10 clk = ~clk;
    capture_write_arbiter #(.ADDR_W(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .port0_st_data  (port0_st_data),
        .port0_st_valid (port0_st_valid),
        .port1_st_data  (port1_st_data),
        .port1_st_valid (port1_st_valid),
        .mem_address    (mem_address),
        .mem_writedata  (mem_writedata),
        .mem_write      (mem_write),
        .mem_waitrequest(mem_waitrequest),
        .csr_address    (csr_address),
        .csr_read       (csr_read),
        .csr_write      (csr_write),
        .csr_writedata  (csr_writedata),
        .csr_readdata   (csr_readdata),
        .snoop_reset    (snoop_reset)
    );
    function automatic bit [31:0] sat(input bit [31:0] x);
        return (x == 32'hFFFF_FFFF) ? x : x + 1;
    endfunction
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    // Advance the model by one clock using the inputs presented at this edge
    task automatic model_update();
        bit acc, go, iss, sel, hit, cw, en_n, wrap_n;
        bit [35:0] hd;
        acc = busy && !mem_waitrequest;
        go = pend && (!busy || acc);
        iss = !busy && st == 1 && !pend && (q0.size() != 0 || q1.size() != 0);
        sel = (q0.size() != 0 && q1.size() != 0) ? !last : (q0.size() == 0);
        hd = '0;
        if (iss) hd = sel ? q1[0] : q0[0];
        cw = csr_write && csr_address == 4'd0;
        en_n = cw ? csr_writedata[0] : en;
        wrap_n = cw ? csr_writedata[1] : wrap;
        hit = acc && st == 1 && addr == AW'(2**AW - 1) && !wrap;
        if (acc) begin
            if (port) begin void'(q1.pop_front()); cnt1++; end
            else begin void'(q0.pop_front()); cnt0++; end
            addr = addr + 1;
            busy = 0;
        end
        if (st == 1) begin
            if (port0_st_valid) begin
                if (q0.size() < DEPTH) q0.push_back(port0_st_data); else drop0 = sat(drop0);
            end
            if (port1_st_valid) begin
                if (q1.size() < DEPTH) q1.push_back(port1_st_data); else drop1 = sat(drop1);
            end
        end else if (st == 2) begin
            if (port0_st_valid) drop0 = sat(drop0);
            if (port1_st_valid) drop1 = sat(drop1);
        end
        if (iss) begin
            busy = 1;
            port = sel;
            last = sel;
            wdat = {4'hF, 23'h0, sel, hd};
        end
        if (go) st = en_n ? 1 : 0;
        else if (!en_n) st = 0;
        else if (st == 0) st = 1;
        else if (hit) st = 2;
        if (go) begin
            q0.delete();
            q1.delete();
            drop0 = 0; drop1 = 0; cnt0 = 0; cnt1 = 0;
            addr = 0;
        end
        snoop = go;
        pend = (cw && csr_writedata[2]) || (pend && !go);
        en = en_n;
        wrap = wrap_n;
    endtask
    function automatic bit [31:0] csr_exp(input int a);
        case (a)
            0: return {30'd0, wrap, en};
            1: return {29'd0, busy, st == 2, st == 1};
            2: return 32'(addr);
            3: return drop0;
            4: return drop1;
            5: return cnt0;
            6: return cnt1;
            default: return 0;
        endcase
    endfunction
    task automatic check_outputs();
        chk("mem_write", mem_write, busy);
        chk("mem_address", mem_address, addr);
        chk("mem_writedata", mem_writedata, wdat);
        chk("snoop_reset", snoop_reset, snoop);
    endtask
    task automatic csr_check();
        for (int a = 0; a < 8; a++) begin
            csr_address = 4'(a);
            csr_read = 1'b1;
            #1;
            chk($sformatf("csr%0d", a), csr_readdata, csr_exp(a));
        end
        csr_read = 1'b0;
    endtask
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check_outputs();
    endtask
    task automatic csr_wr(input bit [31:0] d);
        csr_address = 4'd0;
        csr_writedata = d;
        csr_write = 1'b1;
        step();
        csr_write = 1'b0;
    endtask
    task automatic drive(input bit v0, input bit v1, input bit wr);
        port0_st_valid = v0;
        port1_st_valid = v1;
        port0_st_data = {4'($urandom_range(15)), $urandom()};
        port1_st_data = {4'($urandom_range(15)), $urandom()};
        mem_waitrequest = wr;
    endtask
    task automatic rand_cycles(input int n, input int pv, input int pw);
        for (int k = 0; k < n; k++) begin
            drive($urandom_range(99) < pv, $urandom_range(99) < pv, $urandom_range(99) < pw);
            step();
        end
    endtask
    task automatic wait_busy(input string tag);
        for (int k = 0; k < 8 && !busy; k++) begin
            drive(1, 0, 0);
            step();
        end
        chk(tag, mem_write, 1);
    endtask
    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        csr_check();
        reset_n = 1'b1;
        csr_wr(32'h1);
        for (int k = 1; k <= 3; k++) begin
            port0_st_valid = 1'b1;
            port0_st_data = 36'(k);
            step();
        end
        drive(0, 0, 0);
        repeat (8) step();
        csr_address = 4'd5;
        csr_read = 1'b1;
        #1;
        chk("count0_direct", csr_readdata, 3);
        csr_read = 1'b0;
        csr_check();
        for (int k = 0; k < 8; k++) begin drive(1, 1, 0); step(); end
        csr_check();
        for (int k = 0; k < 10; k++) begin drive(1, 1, 1); step(); end
        csr_check();
        for (int k = 0; k < 24; k++) begin drive(1, 1, 0); step(); end
        chk("status_full", dut.csr_readdata === 32'hx, 0);
        csr_check();
        drive(0, 0, 0);
        csr_wr(32'h5);
        repeat (3) step();
        csr_check();
        wait_busy("busy_before_clear");
        drive(0, 0, 1);
        csr_wr(32'h5);
        for (int k = 0; k < 4; k++) begin drive($urandom_range(1), $urandom_range(1), 1); step(); end
        drive(0, 0, 0);
        repeat (4) step();
        csr_check();
        csr_wr(32'h3);
        rand_cycles(120, 60, 30);
        csr_check();
        wait_busy("busy_before_disable");
        drive(1, 1, 1);
        csr_wr(32'h2);
        for (int k = 0; k < 5; k++) begin drive(1, 1, 1); step(); end
        drive(0, 0, 0);
        repeat (5) step();
        csr_check();
        rand_cycles(5, 80, 0);
        csr_check();
        drive(0, 0, 0);
        csr_wr(32'h3);
        repeat (20) step();
        csr_check();
        for (int k = 0; k < 250; k++) begin
            drive($urandom_range(99) < 55, $urandom_range(99) < 55, $urandom_range(99) < 35);
            if ($urandom_range(99) < 3) csr_wr(32'($urandom_range(7)));
            else step();
            if (k % 50 == 49) csr_check();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
